// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR register bank: conflict-mode encodings and a popcount helper.
package sr_bank_pkg;

  localparam int PRIO_SET    = 0;
  localparam int PRIO_RST    = 1;
  localparam int PRIO_HOLD   = 2;
  localparam int PRIO_TOGGLE = 3;

  typedef logic [1:0] sr_prio_t;

  // Covers any bank up to 32 channels; narrower vectors are zero-extended by the caller.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR channel: registered q / q_n plus one-cycle change and conflict pulses.
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter sr_prio_t PRIORITY = sr_prio_t'(PRIO_SET)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_n,
  output logic changed,
  output logic conflict
);

  logic q_nxt;
  logic conf_nxt;

  always_comb begin
    q_nxt    = q;
    conf_nxt = en & s & r;
    if (en) begin
      unique case ({s, r})
        2'b10: q_nxt = 1'b1;
        2'b01: q_nxt = 1'b0;
        2'b11: begin
          unique case (PRIORITY)
            sr_prio_t'(PRIO_SET):  q_nxt = 1'b1;
            sr_prio_t'(PRIO_RST):  q_nxt = 1'b0;
            sr_prio_t'(PRIO_HOLD): q_nxt = q;
            default:               q_nxt = ~q;
          endcase
        end
        default: q_nxt = q;
      endcase
    end
  end

  // q_n is its own flop so the complement never passes through a gate after q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= 1'b0;
      q_n      <= 1'b1;
      changed  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      q        <= q_nxt;
      q_n      <= ~q_nxt;
      changed  <= q_nxt ^ q;
      conflict <= conf_nxt;
    end
  end

endmodule

// File: rtl/sr_register_bank.sv
// WIDTH-channel SR latch bank with selectable conflict resolution.
// Optional saturating conflict counter enabled by SR_BANK_CONFLICT_CNT_EN.
module sr_register_bank
  import sr_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRIORITY = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] conflict,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] conflict_cnt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(.PRIORITY(sr_prio_t'(PRIORITY))) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .s        (s[i]),
      .r        (r[i]),
      .q        (q[i]),
      .q_n      (q_n[i]),
      .changed  (changed[i]),
      .conflict (conflict[i])
    );
  end

`ifdef SR_BANK_CONFLICT_CNT_EN
  localparam int SUM_W = CNT_W + 6;
  localparam logic [SUM_W-1:0] CNT_MAX = {{6{1'b0}}, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] conf_nxt;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_nxt;

  // Same term each cell registers as its conflict pulse, counted one edge early.
  always_comb begin
    conf_nxt = {WIDTH{en}} & s & r;
    sum      = SUM_W'(conflict_cnt) + SUM_W'(popcount(32'(conf_nxt)));
    cnt_nxt  = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       conflict_cnt <= '0;
    else if (cnt_clr) conflict_cnt <= '0;
    else              conflict_cnt <= cnt_nxt;
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign conflict_cnt   = '0;
`endif

endmodule

// File: tb/tb_sr_register_bank.sv
// Directed bench: one 8-channel set-dominant bank plus four 4-channel banks, one per conflict mode.
module tb_sr_register_bank;

  logic       clk = 1'b0;
  logic       rst_n, en, cnt_clr;
  logic [7:0] s, r, q, q_n, changed, conflict;
  logic [3:0] cnt;
  logic [3:0] s4, r4;
  logic [3:0] q4 [4];
  logic [3:0] qn4 [4];
  logic [3:0] ch4 [4];
  logic [3:0] cf4 [4];
  logic [3:0] cnt4 [4];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_register_bank #(.WIDTH(8), .PRIORITY(0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .q(q), .q_n(q_n),
    .changed(changed), .conflict(conflict), .cnt_clr(cnt_clr), .conflict_cnt(cnt)
  );

  for (genvar g = 0; g < 4; g++) begin : g_p
    sr_register_bank #(.WIDTH(4), .PRIORITY(g), .CNT_W(4)) u (
      .clk(clk), .rst_n(rst_n), .en(en), .s(s4), .r(r4), .q(q4[g]), .q_n(qn4[g]),
      .changed(ch4[g]), .conflict(cf4[g]), .cnt_clr(cnt_clr), .conflict_cnt(cnt4[g])
    );
  end

`ifdef SR_BANK_CONFLICT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; cnt_clr = 1'b0; s = 8'hFF; r = 8'h00; s4 = 4'hF; r4 = 4'h0;
    step(); step();
    chk8("reset_q", q, 8'h00);
    chk8("reset_qn", q_n, 8'hFF);
    chk8("reset_changed", changed, 8'h00);
    chk8("reset_conflict", conflict, 8'h00);
    chk8("reset_cnt", {4'h0, cnt}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; s = 8'h05; r = 8'h00; s4 = 4'h0;
    step();
    chk8("release_q", q, 8'h05);
    chk8("release_qn", q_n, 8'hFA);
    chk8("release_changed", changed, 8'h05);
    @(negedge clk);
    s = 8'h00;
    step();
    chk8("release_hold_q", q, 8'h05);
    chk8("release_changed_drop", changed, 8'h00);
  endtask

  task automatic test_priority();
    logic [3:0] eq [4];
    logic [3:0] ec [4];
    eq[0] = 4'hF; eq[1] = 4'h0; eq[2] = 4'h5; eq[3] = 4'hA;
    ec[0] = 4'hA; ec[1] = 4'h5; ec[2] = 4'h0; ec[3] = 4'hF;
    @(negedge clk);
    s4 = 4'h5; r4 = 4'hA;
    step();
    for (int p = 0; p < 4; p++) chk8($sformatf("prio%0d_preset", p), {4'h0, q4[p]}, 8'h05);
    @(negedge clk);
    s4 = 4'hF; r4 = 4'hF;
    step();
    for (int p = 0; p < 4; p++) begin
      chk8($sformatf("prio%0d_q", p), {4'h0, q4[p]}, {4'h0, eq[p]});
      chk8($sformatf("prio%0d_qn", p), {4'h0, qn4[p]}, {4'h0, ~eq[p]});
      chk8($sformatf("prio%0d_changed", p), {4'h0, ch4[p]}, {4'h0, ec[p]});
      chk8($sformatf("prio%0d_conflict", p), {4'h0, cf4[p]}, 8'h0F);
    end
    @(negedge clk);
    s4 = 4'h0; r4 = 4'h0;
    step();
    for (int p = 0; p < 4; p++) begin
      chk8($sformatf("prio%0d_conflict_drop", p), {4'h0, cf4[p]}, 8'h00);
      chk8($sformatf("prio%0d_hold", p), {4'h0, q4[p]}, {4'h0, eq[p]});
    end
  endtask

  task automatic test_enable();
    @(negedge clk);
    en = 1'b0; s = 8'hAA; r = 8'h55; s4 = 4'hF; r4 = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk8($sformatf("en_off%0d_q", k), q, 8'h05);
      chk8($sformatf("en_off%0d_changed", k), changed, 8'h00);
      chk8($sformatf("en_off%0d_conflict", k), {4'h0, cf4[0]}, 8'h00);
    end
    @(negedge clk);
    en = 1'b1; s4 = 4'h0; r4 = 4'h0;
    step();
    chk8("en_on_q", q, 8'hAA);
    chk8("en_on_qn", q_n, 8'h55);
    chk8("en_on_changed", changed, 8'hAF);
  endtask

  task automatic test_counter();
    logic [3:0] e [3];
    e[0] = CNT_ON ? 4'd8 : 4'd0;
    e[1] = CNT_ON ? 4'd15 : 4'd0;
    e[2] = CNT_ON ? 4'd15 : 4'd0;
    @(negedge clk);
    cnt_clr = 1'b1; s = 8'h00; r = 8'h00;
    step();
    @(negedge clk);
    cnt_clr = 1'b0; s = 8'h01; r = 8'h01;
    step();
    chk8("cnt_single", {4'h0, cnt}, CNT_ON ? 8'h01 : 8'h00);
    chk8("cnt_single_conflict", conflict, 8'h01);
    @(negedge clk);
    cnt_clr = 1'b1; s = 8'h00; r = 8'h00;
    step();
    chk8("cnt_clr_idle", {4'h0, cnt}, 8'h00);
    @(negedge clk);
    cnt_clr = 1'b0; s = 8'hFF; r = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk8($sformatf("cnt_sat%0d", k), {4'h0, cnt}, {4'h0, e[k]});
      chk8($sformatf("cnt_sat%0d_conflict", k), conflict, 8'hFF);
    end
    chk8("cnt_sat_q", q, 8'hFF);
    @(negedge clk);
    cnt_clr = 1'b1;
    step();
    chk8("cnt_clr_priority", {4'h0, cnt}, 8'h00);
    chk8("cnt_clr_conflict", conflict, 8'hFF);
    @(negedge clk);
    cnt_clr = 1'b0; s = 8'h00; r = 8'h00;
    step();
    chk8("cnt_after_clr", {4'h0, cnt}, 8'h00);
    chk8("cnt_conflict_drop", conflict, 8'h00);
    chk8("cnt_off_instances", {4'h0, cnt4[0]}, 8'h00);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    s = 8'h3C; r = 8'hC3;
    step();
    chk8("pre_rst_q", q, 8'h3C);
    chk8("pre_rst_changed", changed, 8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("async_q", q, 8'h00);
    chk8("async_qn", q_n, 8'hFF);
    chk8("async_changed", changed, 8'h00);
    chk8("async_prio3_qn", {4'h0, qn4[3]}, 8'h0F);
    step();
    chk8("async_hold_q", q, 8'h00);
  endtask

  initial begin
    test_reset();
    test_priority();
    test_enable();
    test_counter();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
